timeout_list: RTL and testbench

Parametrised per-task timeout manager for the OS core; the next generation of the single-step timeout decrementer.
- Holds one countdown per task ID and supports set, cancel, query and a decrement-by-N sweep.
- Maintains a zero bitmap and an expiry event queue that reports, one at a time, tasks whose timeout just reached zero.
- Sits beside the scheduler, which issues a decrement sweep per tick and drains expiries to wake tasks.

---
 rtl/timeout_list_if.sv | 36 +++
 rtl/timeout_list.sv | 157 +++++++++++++++
 tb/tb_timeout_list.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/timeout_list_if.sv
// Command, query and expiry-queue signals between the scheduler and timeout_list.
// Latency: none, this is only signal grouping.
// Backpressure: commands are refused while busy_o is high; the scheduler pops expiries with exp_ack_i.
interface timeout_list_if #(
   parameter int NTID = 64,
   parameter int TIDW = 6,
   parameter int TW   = 48,
   parameter int DW   = 16
);
   logic            dec_i;
   logic [DW-1:0]   dec_amt_i;
   logic            set_i;
   logic            clr_i;
   logic            qry_i;
   logic [TIDW-1:0] tid_i;
   logic [TW-1:0]   timeout_i;
   logic            busy_o;
   logic            done_o;
   logic [TW-1:0]   timeout_o;
   logic [NTID-1:0] zeros_o;
   logic            exp_valid_o;
   logic [TIDW-1:0] exp_tid_o;
   logic            exp_ack_i;

   // scheduler side
   modport master (
      output dec_i, dec_amt_i, set_i, clr_i, qry_i, tid_i, timeout_i, exp_ack_i,
      input  busy_o, done_o, timeout_o, zeros_o, exp_valid_o, exp_tid_o
   );

   // timeout manager side
   modport slave (
      input  dec_i, dec_amt_i, set_i, clr_i, qry_i, tid_i, timeout_i, exp_ack_i,
      output busy_o, done_o, timeout_o, zeros_o, exp_valid_o, exp_tid_o
   );
endinterface

// File: rtl/timeout_list.sv
// Per-task timeout table: set/cancel/query entries, decrement-by-N sweep, lowest-first expiry queue.
// Latency: SET/CLR/QRY done_o two cycles after the strobe; DEC sweep done_o NTID+1 cycles after the strobe.
// Backpressure: strobes are dropped while busy_o is high; expiries are held until exp_ack_i pops them.
module timeout_list #(
   parameter int NTID = 64,
   parameter int TIDW = 6,
   parameter int TW   = 48,
   parameter int DW   = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   timeout_list_if.slave bus
);
   localparam int IW = (NTID > 1) ? $clog2(NTID) : 1;

   typedef enum logic [2:0] {S_IDLE, S_DEC, S_SET, S_CLR, S_QRY} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   mem [NTID];
   logic [NTID-1:0] active_q, pend_q;
   logic [NTID-1:0] act_set, act_clr, pend_set, pend_clr;
   logic [IW-1:0]   idx_q;
   logic [TIDW-1:0] tid_q;
   logic [TW-1:0]   tmo_q;
   logic [DW-1:0]   amt_q;
   logic            done_q;
   logic [TW-1:0]   qry_q;
   logic [TIDW-1:0] exp_tid_q;
   logic            busy;
   logic            exp_valid;
   logic            tid_ok;
   logic            last_idx;
   logic [IW-1:0]   tid_idx;
   logic [TW-1:0]   cur_val, amt_ext, dec_val;

   // lowest set bit wins, so scan from the top down
   function automatic logic [TIDW-1:0] lowest(input logic [NTID-1:0] v);
      lowest = '0;
      for (int i = NTID - 1; i >= 0; i--)
         if (v[i]) lowest = TIDW'(i);
   endfunction

   assign tid_ok   = (32'(tid_q) < NTID);
   assign tid_idx  = IW'(tid_q);
   assign last_idx = (idx_q == IW'(NTID - 1));
   assign cur_val  = mem[idx_q];
   assign amt_ext  = TW'(amt_q);
   assign dec_val  = (cur_val <= amt_ext) ? '0 : cur_val - amt_ext;
   assign exp_valid = |pend_q;

   assign bus.busy_o      = busy;
   assign bus.done_o      = done_q;
   assign bus.timeout_o   = qry_q;
   assign bus.zeros_o     = ~active_q;
   assign bus.exp_valid_o = exp_valid;
   assign bus.exp_tid_o   = exp_tid_q;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next state: accept one command from IDLE by priority, sweep until the last index
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if      (bus.dec_i) state_d = S_DEC;
            else if (bus.set_i) state_d = S_SET;
            else if (bus.clr_i) state_d = S_CLR;
            else if (bus.qry_i) state_d = S_QRY;
         end
         S_DEC:   if (last_idx) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   // per-entry active/pending updates; a pending set beats a clear on the same edge
   always_comb begin
      act_set  = '0;
      act_clr  = '0;
      pend_set = '0;
      pend_clr = '0;
      if (bus.exp_ack_i && exp_valid) pend_clr[exp_tid_q] = 1'b1;
      case (state_q)
         S_DEC: begin
            if (active_q[idx_q] && (dec_val == '0)) begin
               act_clr[idx_q]  = 1'b1;
               pend_set[idx_q] = 1'b1;
            end
         end
         S_SET: begin
            if (tid_ok) begin
               pend_clr[tid_idx] = 1'b1;
               if (tmo_q != '0) act_set[tid_idx] = 1'b1;
               else             act_clr[tid_idx] = 1'b1;
            end
         end
         S_CLR: begin
            if (tid_ok) begin
               pend_clr[tid_idx] = 1'b1;
               act_clr[tid_idx]  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // timeout storage; inactive entries are masked on read so no reset is needed here
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         case (state_q)
            S_DEC:   if (active_q[idx_q]) mem[idx_q] <= dec_val;
            S_SET:   if (tid_ok) mem[tid_idx] <= tmo_q;
            S_CLR:   if (tid_ok) mem[tid_idx] <= '0;
            default: ;
         endcase
      end
   end

   // control/datapath registers: operand capture, sweep index, flags, query result, expiry queue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q     <= '0;
         tid_q     <= '0;
         tmo_q     <= '0;
         amt_q     <= '0;
         done_q    <= 1'b0;
         qry_q     <= '0;
         active_q  <= '0;
         pend_q    <= '0;
         exp_tid_q <= '0;
      end else begin
         done_q    <= ((state_q == S_DEC) && last_idx) || (state_q == S_SET) ||
                      (state_q == S_CLR) || (state_q == S_QRY);
         active_q  <= (active_q & ~act_clr) | act_set;
         pend_q    <= (pend_q & ~pend_clr) | pend_set;
         exp_tid_q <= lowest(pend_q);
         if (state_q == S_IDLE) begin
            idx_q <= '0;
            tid_q <= bus.tid_i;
            tmo_q <= bus.timeout_i;
            amt_q <= bus.dec_amt_i;
         end else if (state_q == S_DEC) begin
            idx_q <= idx_q + 1'b1;
         end
         if (state_q == S_QRY)
            qry_q <= (tid_ok && active_q[tid_idx]) ? mem[tid_idx] : '0;
      end
   end
endmodule

// File: tb/tb_timeout_list.sv
// Directed bench for timeout_list: hand-computed expectations for commands, sweeps and expiries.
// Latency: checks done_o timing for each command class.
// Backpressure: exercises dropped strobes while busy and the expiry ack path.
module tb_timeout_list;
   localparam int NTID = 64, TIDW = 6, TW = 48, DW = 16;
   localparam int K_DEC = 0, K_SET = 1, K_CLR = 2, K_QRY = 3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   lat;
   logic saw_done;

   timeout_list_if #(.NTID(NTID), .TIDW(TIDW), .TW(TW), .DW(DW)) bus ();
   timeout_list #(.NTID(NTID), .TIDW(TIDW), .TW(TW), .DW(DW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_strobes();
      bus.dec_i = 1'b0;
      bus.set_i = 1'b0;
      bus.clr_i = 1'b0;
      bus.qry_i = 1'b0;
   endtask

   // issue one command and wait (bounded) for done_o; lat counts cycles from the sampling edge
   task automatic cmd(input int kind, input int tid, input logic [TW-1:0] tmo,
                      input logic [DW-1:0] amt, output int l);
      bus.tid_i     = TIDW'(tid);
      bus.timeout_i = tmo;
      bus.dec_amt_i = amt;
      case (kind)
         K_DEC:   bus.dec_i = 1'b1;
         K_SET:   bus.set_i = 1'b1;
         K_CLR:   bus.clr_i = 1'b1;
         default: bus.qry_i = 1'b1;
      endcase
      step();
      clear_strobes();
      l = 1;
      while (bus.done_o !== 1'b1 && l < 200) begin
         step();
         l++;
      end
      check("done_seen", {63'd0, bus.done_o}, 64'd1);
   endtask

   task automatic qry(input string tag, input int tid, input logic [TW-1:0] exp);
      int l;
      cmd(K_QRY, tid, '0, '0, l);
      check({tag, "_lat"}, 64'(l), 64'd2);
      check(tag, 64'(bus.timeout_o), 64'(exp));
   endtask

   task automatic ack();
      bus.exp_ack_i = 1'b1;
      step();
      bus.exp_ack_i = 1'b0;
      step();
   endtask

   initial begin
      clear_strobes();
      bus.exp_ack_i = 1'b0;
      bus.tid_i     = '0;
      bus.timeout_i = '0;
      bus.dec_amt_i = '0;
      rst_i = 1'b1;
      repeat (3) step();
      rst_i = 1'b0;

      // reset state
      check("rst_busy",  {63'd0, bus.busy_o}, 64'd0);
      check("rst_done",  {63'd0, bus.done_o}, 64'd0);
      check("rst_tmo",   64'(bus.timeout_o), 64'd0);
      check("rst_zeros", bus.zeros_o, {64{1'b1}});
      check("rst_expv",  {63'd0, bus.exp_valid_o}, 64'd0);
      check("rst_expt",  64'(bus.exp_tid_o), 64'd0);
      qry("q5_rst", 5, 0);
      check("q5_busy", {63'd0, bus.busy_o}, 64'd0);

      // SET 3=10 then three sweeps of 4
      cmd(K_SET, 3, 10, 0, lat);
      check("set_lat", 64'(lat), 64'd2);
      check("z3_set", {63'd0, bus.zeros_o[3]}, 64'd0);
      cmd(K_DEC, 0, 0, 4, lat);
      check("dec1_lat", 64'(lat), 64'(NTID + 1));
      qry("q3_6", 3, 6);
      cmd(K_DEC, 0, 0, 4, lat);
      check("dec2_lat", 64'(lat), 64'(NTID + 1));
      qry("q3_2", 3, 2);
      check("expv_2", {63'd0, bus.exp_valid_o}, 64'd0);
      cmd(K_DEC, 0, 0, 4, lat);
      check("dec3_lat", 64'(lat), 64'(NTID + 1));
      check("expv_3", {63'd0, bus.exp_valid_o}, 64'd1);
      check("expt_3", 64'(bus.exp_tid_o), 64'd3);
      check("z3_exp", {63'd0, bus.zeros_o[3]}, 64'd1);
      qry("q3_0", 3, 0);
      ack();
      check("expv_ack3", {63'd0, bus.exp_valid_o}, 64'd0);

      // two equal expiries, presented lowest first
      cmd(K_SET, 7, 5, 0, lat);
      cmd(K_SET, 2, 5, 0, lat);
      cmd(K_DEC, 0, 0, 5, lat);
      check("z2", {63'd0, bus.zeros_o[2]}, 64'd1);
      check("z7", {63'd0, bus.zeros_o[7]}, 64'd1);
      check("expv_27", {63'd0, bus.exp_valid_o}, 64'd1);
      check("expt_2", 64'(bus.exp_tid_o), 64'd2);
      ack();
      check("expv_7", {63'd0, bus.exp_valid_o}, 64'd1);
      check("expt_7", 64'(bus.exp_tid_o), 64'd7);
      ack();
      check("expv_none", {63'd0, bus.exp_valid_o}, 64'd0);

      // cancel suppresses expiry; zero timeout raises none
      cmd(K_SET, 9, 3, 0, lat);
      cmd(K_CLR, 9, 0, 0, lat);
      check("clr_lat", 64'(lat), 64'd2);
      cmd(K_DEC, 0, 0, 10, lat);
      check("expv_clr", {63'd0, bus.exp_valid_o}, 64'd0);
      qry("q9_0", 9, 0);
      cmd(K_SET, 9, 0, 0, lat);
      check("z9_set0", {63'd0, bus.zeros_o[9]}, 64'd1);
      check("expv_set0", {63'd0, bus.exp_valid_o}, 64'd0);

      // zero decrement keeps value; amount above value saturates to expiry
      cmd(K_SET, 10, 3, 0, lat);
      cmd(K_DEC, 0, 0, 0, lat);
      qry("q10_3", 10, 3);
      check("expv_dec0", {63'd0, bus.exp_valid_o}, 64'd0);
      cmd(K_DEC, 0, 0, 5, lat);
      check("expt_10", 64'(bus.exp_tid_o), 64'd10);
      qry("q10_0", 10, 0);
      ack();
      check("expv_ack10", {63'd0, bus.exp_valid_o}, 64'd0);

      // dec and set together: sweep wins, set dropped
      bus.set_i = 1'b1;
      cmd(K_DEC, 12, 77, 1, lat);
      check("decset_lat", 64'(lat), 64'(NTID + 1));
      qry("q12_drop", 12, 0);

      // set while busy is ignored
      cmd(K_SET, 12, 50, 0, lat);
      bus.dec_amt_i = '0;
      bus.dec_i = 1'b1;
      step();
      bus.dec_i = 1'b0;
      repeat (5) step();
      check("busy_mid", {63'd0, bus.busy_o}, 64'd1);
      bus.tid_i = TIDW'(12);
      bus.timeout_i = 99;
      bus.set_i = 1'b1;
      step();
      bus.set_i = 1'b0;
      lat = 0;
      while (bus.done_o !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      check("busy_done", {63'd0, bus.done_o}, 64'd1);
      step();
      qry("q12_50", 12, 50);

      // reset in the middle of a sweep at index 20
      cmd(K_SET, 1, 1, 0, lat);
      cmd(K_SET, 30, 100, 0, lat);
      bus.dec_amt_i = 1;
      bus.dec_i = 1'b1;
      step();
      bus.dec_i = 1'b0;
      repeat (20) step();
      check("pre_rst_expv", {63'd0, bus.exp_valid_o}, 64'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("mr_busy",  {63'd0, bus.busy_o}, 64'd0);
      check("mr_done",  {63'd0, bus.done_o}, 64'd0);
      check("mr_zeros", bus.zeros_o, {64{1'b1}});
      check("mr_expv",  {63'd0, bus.exp_valid_o}, 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < NTID + 5; i++) begin
         step();
         if (bus.done_o === 1'b1) saw_done = 1'b1;
      end
      check("mr_no_done", {63'd0, saw_done}, 64'd0);
      qry("q30_rst", 30, 0);
      qry("q12_rst", 12, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
